instr_fetch: RTL

- Fetch stage directly upstream of `control`.
- Keeps the program counter and reads instruction words from instruction memory using a req/ack handshake.
- Holds each word in an instruction register and presents it, with its opcode field split out, to `control` through a valid/ready handshake.
- Accepts branch/jump redirects from the execute side.

---
 rtl/instr_fetch.sv | 133 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding `control`.
// Keeps the PC, reads instruction words over a req/ack memory handshake,
// latches each word and offers it over a valid/ready handshake.
// Branch/jump redirects from execute retarget the PC. A redirect that
// lands while a memory request is outstanding is parked until the ack.
// Optional feature: define FETCH_HALT_EN to stop fetching once an
// instruction with opcode HALT_OPCODE is consumed (only rst restarts).
module instr_fetch #(
    parameter int unsigned          ADDR_W      = 8,
    parameter int unsigned          INSTR_W     = 16,
    parameter int unsigned          OPCODE_W    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
    parameter logic [OPCODE_W-1:0]  HALT_OPCODE = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                halted
);

`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {S_REQ, S_HOLD, S_FLUSH, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_HOLD, S_FLUSH} state_t;
`endif

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pending_pc;
    logic                halt_hit;

    assign opcode = instr_out[INSTR_W-1 -: OPCODE_W];

`ifdef FETCH_HALT_EN
    assign halt_hit = (opcode == HALT_OPCODE);
`else
    assign halt_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_REQ;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                // ack plus redirect drops the word and re-requests at the target
                if (imem_ack)      state_nxt = redirect ? S_REQ : S_HOLD;
                else if (redirect) state_nxt = S_FLUSH;
            end
            S_HOLD: begin
                if (instr_ready)   state_nxt = halt_hit ? state_t'(3) : S_REQ;
                else if (redirect) state_nxt = S_REQ;
            end
            S_FLUSH: begin
                if (imem_ack) state_nxt = S_REQ;
            end
            default: state_nxt = state;
        endcase
    end

    // Memory request outputs; held low while reset is asserted
    always_comb begin
        imem_req  = !rst && ((state == S_REQ) || (state == S_FLUSH));
        imem_addr = pc;
    end

    // PC, instruction register and redirect bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            pending_pc  <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            pc <= redirect_pc;
                        end else begin
                            instr_out   <= imem_rdata;
                            instr_pc    <= pc;
                            pc          <= pc + ADDR_W'(1);
                            instr_valid <= 1'b1;
                        end
                    end else if (redirect) begin
                        pending_pc <= redirect_pc;
                    end
                end
                S_HOLD: begin
                    if (instr_ready || redirect) begin
                        instr_valid <= 1'b0;
                        if (redirect) pc <= redirect_pc;
                    end
                end
                S_FLUSH: begin
                    // A redirect arriving with the ack is the newest target
                    if (imem_ack)      pc <= redirect ? redirect_pc : pending_pc;
                    else if (redirect) pending_pc <= redirect_pc;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_HALT_EN
    // Halt flag: set when a halt instruction is consumed, cleared only by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                 halted <= 1'b0;
        else if (state == S_HOLD && instr_ready && halt_hit)     halted <= 1'b1;
    end
`else
    assign halted = 1'b0;
`endif

endmodule
